ta_param_fifo: RTL and testbench

Write-side front end of the Tile Accelerator. It accepts SH4 data-bus writes that hit the TA FIFO window (0x1000_0000–0x107F_FFFF) and assembles them into 32-byte TA parameter packets. It buffers up to DEPTH complete packets and streams them, one 64-bit word per handshake, into the PVR/TA parameter parser. It sits between the core's `dm_req_*` bus decode and `pvr`, and back-pressures the CPU with a write acknowledge when the buffer is full.

---
 rtl/pvr_pkg.sv | 45 ++++
 rtl/ta_pkt_ram.sv | 42 ++++
 rtl/ta_param_fifo.sv | 146 ++++++++++++++
 tb/tb_ta_param_fifo.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pvr_pkg.sv
// PVR shared definitions: TA packet geometry, bus windows,
// the streamed word bundle and byte-lane helpers.
package pvr_pkg;

    localparam int TA_PKT_BYTES = 32;
    localparam int TA_PKT_WORDS = 4;

    localparam logic [31:0] TA_FIFO_BASE  = 32'h1000_0000;
    localparam logic [31:0] TA_FIFO_LIMIT = 32'h107F_FFFF;
    localparam logic [31:0] TA_YUV_BASE   = 32'h1080_0000;
    localparam logic [31:0] TA_YUV_LIMIT  = 32'h10FF_FFFF;
    localparam logic [31:0] TA_TEX_BASE   = 32'h1100_0000;
    localparam logic [31:0] TA_TEX_LIMIT  = 32'h11FF_FFFF;

    typedef struct packed {
        logic [63:0] data;
        logic [1:0]  idx;
        logic        last;
    } ta_word_t;

    // Map an 8-bit lane mask of word 'word' onto the packet byte vector.
    function automatic logic [TA_PKT_BYTES-1:0] byte_sel(
        input logic [1:0] word,
        input logic [7:0] mask
    );
        logic [TA_PKT_BYTES-1:0] v;
        v = {{(TA_PKT_BYTES-8){1'b0}}, mask};
        return v << {word, 3'b000};
    endfunction

    // Byte-lane merge of new data over old data.
    function automatic logic [63:0] merge_bytes(
        input logic [63:0] old_w,
        input logic [63:0] new_w,
        input logic [7:0]  mask
    );
        logic [63:0] r;
        r = old_w;
        for (int i = 0; i < 8; i++) begin
            if (mask[i]) r[8*i +: 8] = new_w[8*i +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/ta_pkt_ram.sv
// Packet store: whole-packet write port, registered word read port
// with write-through when the read targets the packet being written.
module ta_pkt_ram
    import pvr_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH)
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         we,
    input  logic [PW-1:0]                waddr,
    input  logic [TA_PKT_WORDS-1:0][63:0] wdata,
    input  logic [PW-1:0]                raddr_pkt,
    input  logic [1:0]                   raddr_word,
    output logic [63:0]                  rdata
);

    logic [63:0] mem [DEPTH*TA_PKT_WORDS];

    // Store all four words of a packet in one cycle.
    always_ff @(posedge clock) begin
        if (we) begin
            for (int w = 0; w < TA_PKT_WORDS; w++) begin
                mem[{waddr, 2'(w)}] <= wdata[w];
            end
        end
    end

    // Registered read; bypass lets a packet pushed into an empty
    // FIFO show its first word on the very next cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rdata <= '0;
        end else if (we && waddr == raddr_pkt) begin
            rdata <= wdata[raddr_word];
        end else begin
            rdata <= mem[{raddr_pkt, raddr_word}];
        end
    end

endmodule

// File: rtl/ta_param_fifo.sv
// TA FIFO write front end: assembles CPU writes into 32-byte
// parameter packets and streams them out one 64-bit word at a time.
module ta_param_fifo
    import pvr_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       ta_fifo_cs,
    input  logic                       wr,
    input  logic [4:0]                 addr,
    input  logic [63:0]                wdata,
    input  logic [7:0]                 wmask,
    output logic                       wr_ack,
    input  logic                       flush,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [63:0]                out_data,
    output logic [1:0]                 out_word,
    output logic                       out_last,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       err_dup
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);

    logic [TA_PKT_WORDS-1:0][63:0] asm_q;
    logic [TA_PKT_WORDS-1:0][63:0] asm_d;
    logic [TA_PKT_BYTES-1:0]       bv_q;
    logic [TA_PKT_BYTES-1:0]       bv_new;
    logic [TA_PKT_BYTES-1:0]       sel;
    logic                          present;
    logic                          completing;
    logic                          full;
    logic                          accept;
    logic                          push;
    logic                          pop;
    logic                          hs;
    logic                          dup;
    logic [PW-1:0]                 wptr_q;
    logic [PW-1:0]                 head_q;
    logic [PW-1:0]                 head_d;
    logic [1:0]                    wcnt_q;
    logic [1:0]                    wcnt_d;
    logic [LW-1:0]                 level_q;
    logic                          err_q;
    logic                          ack_q;
    logic [63:0]                   rdata;
    ta_word_t                      head_word;
    logic                          unused_addr;

    assign unused_addr = ^addr[2:0];

    // Write acceptance, merge and read-pointer next state.
    always_comb begin
        present    = wr && ta_fifo_cs;
        sel        = byte_sel(addr[4:3], wmask);
        bv_new     = bv_q | sel;
        completing = &bv_new;
        full       = (level_q == LW'(DEPTH));
        accept     = present && (flush || !completing || !full);
        push       = accept && completing && !flush;
        dup        = accept && !flush && |(sel & bv_q);
        asm_d      = asm_q;
        asm_d[addr[4:3]] = merge_bytes(asm_q[addr[4:3]], wdata, wmask);
        hs         = (level_q != '0) && out_ready;
        pop        = hs && (wcnt_q == 2'd3);
        wcnt_d     = wcnt_q;
        head_d     = head_q;
        if (flush) begin
            wcnt_d = '0;
            head_d = '0;
        end else begin
            if (hs)  wcnt_d = wcnt_q + 2'd1;
            if (pop) head_d = head_q + PW'(1);
        end
    end

    // Assembly buffer and byte-valid tracking.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            asm_q <= '0;
            bv_q  <= '0;
        end else if (flush) begin
            bv_q  <= '0;
        end else if (accept) begin
            asm_q <= asm_d;
            bv_q  <= completing ? '0 : bv_new;
        end
    end

    // Pointers, packet count, duplicate flag and write acknowledge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wptr_q  <= '0;
            head_q  <= '0;
            wcnt_q  <= '0;
            level_q <= '0;
            err_q   <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            ack_q  <= accept;
            head_q <= head_d;
            wcnt_q <= wcnt_d;
            if (flush) begin
                wptr_q  <= '0;
                level_q <= '0;
                err_q   <= 1'b0;
            end else begin
                if (push) wptr_q <= wptr_q + PW'(1);
                if (dup)  err_q  <= 1'b1;
                unique case ({push, pop})
                    2'b10:   level_q <= level_q + LW'(1);
                    2'b01:   level_q <= level_q - LW'(1);
                    default: level_q <= level_q;
                endcase
            end
        end
    end

    ta_pkt_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clock      (clock),
        .reset_n    (reset_n),
        .we         (push),
        .waddr      (wptr_q),
        .wdata      (asm_d),
        .raddr_pkt  (head_d),
        .raddr_word (wcnt_d),
        .rdata      (rdata)
    );

    assign head_word = '{data: rdata, idx: wcnt_q, last: (wcnt_q == 2'd3)};

    assign wr_ack    = ack_q;
    assign out_valid = (level_q != '0);
    assign out_data  = head_word.data;
    assign out_word  = head_word.idx;
    assign out_last  = head_word.last;
    assign level     = level_q;
    assign err_dup   = err_q;

endmodule

// File: tb/tb_ta_param_fifo.sv
// Directed bench for ta_param_fifo: output words are checked
// against a scoreboard filled as packets are written.
module tb_ta_param_fifo;

    typedef struct {
        logic [63:0] data;
        logic [1:0]  word;
        logic        last;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset_n = 1'b1;
    logic        ta_fifo_cs = 1'b0;
    logic        wr = 1'b0;
    logic [4:0]  addr = '0;
    logic [63:0] wdata = '0;
    logic [7:0]  wmask = '0;
    logic        wr_ack;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_data;
    logic [1:0]  out_word;
    logic        out_last;
    logic [2:0]  level;
    logic        err_dup;

    int   n_chk = 0;
    int   n_pass = 0;
    exp_t exp_q[$];
    exp_t mon_e;

    ta_param_fifo #(.DEPTH(4)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .ta_fifo_cs (ta_fifo_cs),
        .wr         (wr),
        .addr       (addr),
        .wdata      (wdata),
        .wmask      (wmask),
        .wr_ack     (wr_ack),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_word   (out_word),
        .out_last   (out_last),
        .level      (level),
        .err_dup    (err_dup)
    );

    always #5 clock = ~clock;

    initial begin
        #400000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic sb_push(input logic [63:0] d, input int idx);
        exp_q.push_back('{data: d, word: 2'(idx), last: (idx == 3)});
    endtask

    task automatic wr_word(input logic [4:0] a, input logic [63:0] d,
                           input logic [7:0] m);
        wr = 1'b1;
        ta_fifo_cs = 1'b1;
        addr = a;
        wdata = d;
        wmask = m;
        @(posedge clock);
        #1;
        wr = 1'b0;
        chk("wr_ack", 64'(wr_ack), 64'd1);
    endtask

    task automatic send_pkt(input logic [63:0] d0, input logic [63:0] d1,
                            input logic [63:0] d2, input logic [63:0] d3);
        logic [63:0] d [4];
        d = '{d0, d1, d2, d3};
        for (int i = 0; i < 4; i++) begin
            sb_push(d[i], i);
            wr_word(5'(i * 8), d[i], 8'hFF);
        end
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        out_ready = 1'b1;
        while ((out_valid || exp_q.size() != 0) && n < 200) begin
            @(posedge clock);
            #1;
            n++;
        end
        out_ready = 1'b0;
        chk({tag, "_level"}, 64'(level), 64'd0);
        chk({tag, "_sb_empty"}, 64'(exp_q.size()), 64'd0);
    endtask

    // Scoreboard consumer: every accepted head word is compared.
    always @(negedge clock) begin
        if (reset_n && out_valid && out_ready) begin
            chk("sb_has_entry", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                chk("out_data", out_data, mon_e.data);
                chk("out_word", 64'(out_word), 64'(mon_e.word));
                chk("out_last", 64'(out_last), 64'(mon_e.last));
            end
        end
    end

    initial begin
        logic [63:0] w [4];
        int k;
        int n;

        // reset
        #2 reset_n = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #1 reset_n = 1'b1;
        chk("rst_wr_ack", 64'(wr_ack), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_out_word", 64'(out_word), 64'd0);
        chk("rst_out_last", 64'(out_last), 64'd0);
        chk("rst_level", 64'(level), 64'd0);
        chk("rst_err_dup", 64'(err_dup), 64'd0);

        // basic packet
        out_ready = 1'b1;
        send_pkt(64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
                 64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444);
        chk("basic_level1", 64'(level), 64'd1);
        chk("basic_valid", 64'(out_valid), 64'd1);
        drain("basic");

        // mixed widths, reverse address order
        w = '{64'hA0A1_A2A3_A4A5_A6A7, 64'hB0B1_B2B3_B4B5_B6B7,
              64'hC0C1_C2C3_C4C5_C6C7, 64'hD0D1_D2D3_D4D5_D6D7};
        k = 0;
        for (int wi = 3; wi >= 0; wi--) begin
            wr_word(5'(wi * 8), {w[wi][63:32], 32'hDEAD_BEEF}, 8'hF0);
            k++;
            wr_word(5'(wi * 8), {32'hCAFE_F00D, w[wi][31:0]}, 8'h0F);
            k++;
            if (k == 6) chk("mixed_no_early", 64'(out_valid), 64'd0);
        end
        chk("mixed_valid", 64'(out_valid), 64'd1);
        chk("mixed_level", 64'(level), 64'd1);
        chk("mixed_first", out_data, w[0]);
        repeat (2) @(posedge clock);
        #1;
        chk("mixed_stable_data", out_data, w[0]);
        chk("mixed_stable_word", 64'(out_word), 64'd0);
        for (int i = 0; i < 4; i++) sb_push(w[i], i);
        drain("mixed");

        // full back-pressure
        for (int p = 0; p < 4; p++) begin
            send_pkt({32'h5000_0000 + 32'(p), 32'h0},
                     {32'h5100_0000 + 32'(p), 32'h1},
                     {32'h5200_0000 + 32'(p), 32'h2},
                     {32'h5300_0000 + 32'(p), 32'h3});
        end
        chk("full_level4", 64'(level), 64'd4);
        w = '{64'h6000_0000_0000_0000, 64'h6100_0000_0000_0001,
              64'h6200_0000_0000_0002, 64'h6300_0000_0000_0003};
        for (int i = 0; i < 4; i++) sb_push(w[i], i);
        for (int i = 0; i < 3; i++) wr_word(5'(i * 8), w[i], 8'hFF);
        wr = 1'b1;
        ta_fifo_cs = 1'b1;
        addr = 5'h18;
        wdata = w[3];
        wmask = 8'hFF;
        repeat (3) begin
            @(posedge clock);
            #1;
            chk("full_held_ack", 64'(wr_ack), 64'd0);
        end
        chk("full_held_level", 64'(level), 64'd4);
        out_ready = 1'b1;
        repeat (4) begin
            @(posedge clock);
            #1;
            chk("full_ack_during_pop", 64'(wr_ack), 64'd0);
        end
        out_ready = 1'b0;
        chk("full_after_pop", 64'(level), 64'd3);
        @(posedge clock);
        #1;
        wr = 1'b0;
        chk("full_late_ack", 64'(wr_ack), 64'd1);
        chk("full_level_back", 64'(level), 64'd4);
        @(posedge clock);
        #1;
        chk("full_ack_pulse", 64'(wr_ack), 64'd0);
        drain("full");

        // duplicate byte
        wr_word(5'h00, 64'h0000_0000_0000_00AA, 8'h01);
        chk("dup_clear", 64'(err_dup), 64'd0);
        wr_word(5'h00, 64'h0000_0000_0000_00BB, 8'h01);
        chk("dup_set", 64'(err_dup), 64'd1);
        wr_word(5'h00, 64'h0102_0304_0506_0700, 8'hFE);
        sb_push(64'h0102_0304_0506_07BB, 0);
        w = '{64'h0, 64'h7777_0000_0000_0001,
              64'h7777_0000_0000_0002, 64'h7777_0000_0000_0003};
        for (int i = 1; i < 4; i++) begin
            sb_push(w[i], i);
            wr_word(5'(i * 8), w[i], 8'hFF);
        end
        drain("dup");
        chk("dup_sticky", 64'(err_dup), 64'd1);

        // flush mid-packet
        out_ready = 1'b1;
        wr_word(5'h00, 64'hBAD0_0000_0000_0000, 8'hFF);
        wr_word(5'h08, 64'hBAD1_0000_0000_0000, 8'hFF);
        flush = 1'b1;
        wr = 1'b1;
        addr = 5'h10;
        wdata = 64'hBAD2_0000_0000_0000;
        wmask = 8'hFF;
        @(posedge clock);
        #1;
        flush = 1'b0;
        wr = 1'b0;
        out_ready = 1'b0;
        chk("flush_ack", 64'(wr_ack), 64'd1);
        chk("flush_err", 64'(err_dup), 64'd0);
        chk("flush_valid", 64'(out_valid), 64'd0);
        chk("flush_level", 64'(level), 64'd0);
        send_pkt(64'h8000_0000_0000_0000, 64'h8100_0000_0000_0001,
                 64'h8200_0000_0000_0002, 64'h8300_0000_0000_0003);
        chk("flush_new_err", 64'(err_dup), 64'd0);
        chk("flush_new_level", 64'(level), 64'd1);
        drain("flush");
        repeat (4) @(posedge clock);
        #1;
        chk("flush_one_pkt", 64'(out_valid), 64'd0);

        // reset mid-stream
        send_pkt(64'h9000_0000_0000_0000, 64'h9100_0000_0000_0001,
                 64'h9200_0000_0000_0002, 64'h9300_0000_0000_0003);
        send_pkt(64'h9400_0000_0000_0004, 64'h9500_0000_0000_0005,
                 64'h9600_0000_0000_0006, 64'h9700_0000_0000_0007);
        chk("rstm_level2", 64'(level), 64'd2);
        out_ready = 1'b1;
        n = 0;
        while (out_word != 2'd1 && n < 20) begin
            @(posedge clock);
            #1;
            n++;
        end
        chk("rstm_at_word1", 64'(out_word), 64'd1);
        reset_n = 1'b0;
        #1;
        chk("rstm_wr_ack", 64'(wr_ack), 64'd0);
        chk("rstm_valid", 64'(out_valid), 64'd0);
        chk("rstm_data", out_data, 64'd0);
        chk("rstm_word", 64'(out_word), 64'd0);
        chk("rstm_last", 64'(out_last), 64'd0);
        chk("rstm_level", 64'(level), 64'd0);
        chk("rstm_err", 64'(err_dup), 64'd0);
        out_ready = 1'b0;
        exp_q.delete();
        @(posedge clock);
        #1 reset_n = 1'b1;
        @(posedge clock);
        #1;
        chk("rstm_rel_level", 64'(level), 64'd0);
        chk("rstm_rel_valid", 64'(out_valid), 64'd0);
        send_pkt(64'hE000_0000_0000_0000, 64'hE100_0000_0000_0001,
                 64'hE200_0000_0000_0002, 64'hE300_0000_0000_0003);
        drain("rstm_after");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
